instr_encoder: RTL and testbench
================================

INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter ADDR_W, default 64: instruction-memory address width.
REQ-002 Parameter CNT_W, default 16: width of the written-instruction counter.
REQ-003 clk  input  1  rising-edge clock; the only clock.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 start  input  1  load base_addr into the write pointer and clear count.
REQ-006 base_addr  input  ADDR_W  byte address of the first instruction word.
REQ-007 in_valid  input  1  encode request valid.
REQ-008 in_ready  output  1  encoder can accept a request.
REQ-009 fmt  input  2  format select: 00 I-ALU (opcode 0010011), 01 load (0000011), 10 store (0100011), 11 branch (1100011).
REQ-010 rd, rs1, rs2  input  5 each  register fields; rd is ignored for store/branch, rs2 is ignored for I-ALU/load.
REQ-011 funct3  input  3  funct3 field, placed unchanged.
REQ-012 imm  input  64  signed immediate; for branch, a byte offset.
REQ-013 mem_we  output  1  instruction-memory write strobe.
REQ-014 mem_addr  output  ADDR_W  write byte address.
REQ-015 mem_wdata  output  32  encoded instruction word.
REQ-016 mem_ready  input  1  memory accepts the write this cycle.
REQ-017 err  output  1  one-cycle pulse for an unencodable request.
REQ-018 count  output  CNT_W  number of instructions written since start/reset.
REQ-019 busy  output  1  high whenever the state is not IDLE.

Function
REQ-020 FSM states SHALL be IDLE, ENCODE and WRITE.
REQ-021 in_ready SHALL equal (state==IDLE) && !start && !reset.
REQ-022 IDLE + start SHALL load mem_addr<=base_addr and count<=0; start SHALL take precedence over in_valid in the same cycle; start outside IDLE SHALL be ignored.
REQ-023 The request is accepted when in_valid && in_ready; the inputs SHALL be captured, the state moves to ENCODE, and the captured values are not affected by later input changes.
REQ-024 ENCODE SHALL register mem_wdata and the range-check result, then move to WRITE if legal or to IDLE if illegal.
REQ-025 The range check SHALL be: I-ALU/load/store, imm in [-2048, 2047]; branch, imm in [-4096, 4094] with imm[0]==0.
REQ-026 Illegal requests SHALL assert err for exactly the cycle after ENCODE, produce no mem_we, and leave mem_addr and count unchanged.
REQ-027 I-ALU/load encoding SHALL be {imm[11:0], rs1, funct3, rd, opcode}.
REQ-028 Store encoding SHALL be {imm[11:5], rs2, rs1, funct3, imm[4:0], 0100011}.
REQ-029 Branch encoding SHALL be {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 1100011}.
REQ-030 WRITE SHALL hold mem_we=1 with mem_addr and mem_wdata stable until mem_ready=1.
REQ-031 On the mem_we && mem_ready cycle, the block SHALL take mem_addr<=mem_addr+4 (modulo 2^ADDR_W), increment count (saturating at all-ones), and return to IDLE.
REQ-032 Latency SHALL be: request accepted at cycle N, mem_we high at N+2; throughput is at most one instruction per 3 cycles.
REQ-033 mem_we SHALL be low in IDLE and ENCODE.
REQ-034 mem_wdata SHALL keep its last value outside WRITE.

Reset
REQ-035 While reset is high at a clock edge, the next state SHALL be IDLE with mem_we=0, mem_addr=0, mem_wdata=0, count=0, err=0, busy=0.
REQ-036 Reset SHALL override all other inputs in any state, including mid-WRITE; an in-flight write is dropped.
REQ-037 After reset, in_ready SHALL be 1 in the first cycle with reset low.

Verification
REQ-038 Start with base_addr=0x1000, then fmt=00, rd=5, rs1=6, funct3=0, imm=-1 -> mem_we at N+2, mem_addr=0x1000, mem_wdata=0xFFF30293, then count=1.
REQ-039 fmt=10, rs1=2, rs2=5, funct3=3, imm=8 -> mem_wdata=0x00513423, mem_addr advanced by 4.
REQ-040 fmt=11, rs1=1, rs2=2, funct3=0, imm=-4 -> mem_wdata=0xFE208EE3.
REQ-041 fmt=00 with imm=2048, then fmt=11 with imm=3 -> err pulses once each, no mem_we, count unchanged.
REQ-042 Hold mem_ready=0 for 3 cycles during WRITE -> mem_we, mem_addr and mem_wdata stable with in_ready=0; after mem_ready=1, mem_addr+4 and IDLE.
REQ-043 Assert reset for one cycle during WRITE -> next cycle mem_we=0, mem_addr=0, count=0, in_ready=1 after reset is released.

Source files
------------

// File: rtl/instr_encoder.sv
// instr_encoder: encodes I-ALU / load / store / branch requests into RV32
// instruction words and writes them sequentially into instruction memory.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start, base_addr    (IDLE only) load write pointer, clear count
//   in_valid, in_ready  request handshake
//   fmt, rd, rs1, rs2, funct3, imm   request fields
//   mem_we, mem_addr, mem_wdata, mem_ready   memory write port
//   err                 one-cycle pulse for an unencodable request
//   count               instructions written since start/reset (saturating)
//   busy                state != IDLE
//
// Flow: IDLE (accept) -> ENCODE (build word, range check) -> WRITE (hold
// until mem_ready) -> IDLE. Illegal requests go ENCODE -> IDLE with err.
module instr_encoder #(
    parameter int ADDR_W = 64,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        fmt,
    input  logic [4:0]        rd,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [2:0]        funct3,
    input  logic [63:0]       imm,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    output logic              err,
    output logic [CNT_W-1:0]  count,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ENCODE, WRITE} state_t;

    localparam logic [1:0] FMT_IALU   = 2'b00;
    localparam logic [1:0] FMT_LOAD   = 2'b01;
    localparam logic [1:0] FMT_STORE  = 2'b10;
    localparam logic [1:0] FMT_BRANCH = 2'b11;

    state_t state, state_next;

    // Captured request
    logic [1:0]  req_fmt;
    logic [4:0]  req_rd, req_rs1, req_rs2;
    logic [2:0]  req_funct3;
    logic [63:0] req_imm;

    logic [31:0] enc_word;
    logic        enc_legal;

    assign in_ready = (state == IDLE) && !start && !reset;
    assign mem_we   = (state == WRITE);
    assign busy     = (state != IDLE);

    // Word assembly and immediate range check from the captured request
    always_comb begin
        logic signed [63:0] simm;
        simm      = $signed(req_imm);
        enc_word  = '0;
        enc_legal = 1'b0;
        case (req_fmt)
            FMT_IALU: begin
                enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0010011};
                enc_legal = (simm >= -64'sd2048) && (simm <= 64'sd2047);
            end
            FMT_LOAD: begin
                enc_word  = {req_imm[11:0], req_rs1, req_funct3, req_rd, 7'b0000011};
                enc_legal = (simm >= -64'sd2048) && (simm <= 64'sd2047);
            end
            FMT_STORE: begin
                enc_word  = {req_imm[11:5], req_rs2, req_rs1, req_funct3,
                             req_imm[4:0], 7'b0100011};
                enc_legal = (simm >= -64'sd2048) && (simm <= 64'sd2047);
            end
            FMT_BRANCH: begin
                enc_word  = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                             req_imm[4:1], req_imm[11], 7'b1100011};
                // branch offsets are halfword aligned
                enc_legal = (simm >= -64'sd4096) && (simm <= 64'sd4094) && !req_imm[0];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (!start && in_valid) state_next = ENCODE;
            ENCODE:  state_next = enc_legal ? WRITE : IDLE;
            WRITE:   if (mem_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr   <= '0;
            mem_wdata  <= '0;
            count      <= '0;
            err        <= 1'b0;
            req_fmt    <= '0;
            req_rd     <= '0;
            req_rs1    <= '0;
            req_rs2    <= '0;
            req_funct3 <= '0;
            req_imm    <= '0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        mem_addr <= base_addr;
                        count    <= '0;
                    end else if (in_valid) begin
                        req_fmt    <= fmt;
                        req_rd     <= rd;
                        req_rs1    <= rs1;
                        req_rs2    <= rs2;
                        req_funct3 <= funct3;
                        req_imm    <= imm;
                    end
                end
                ENCODE: begin
                    // an illegal word is never exposed; mem_wdata keeps the last written word
                    if (enc_legal) mem_wdata <= enc_word;
                    else           err       <= 1'b1;
                end
                WRITE: begin
                    if (mem_ready) begin
                        mem_addr <= mem_addr + ADDR_W'(4);
                        if (count != '1) count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized self-checking bench for instr_encoder, with a behavioural
// model of the write pointer, count and instruction encoding.
module tb_instr_encoder;

    logic        clk = 0;
    logic        reset, start, in_valid, in_ready, mem_we, mem_ready, err, busy;
    logic [63:0] base_addr, mem_addr, imm;
    logic [1:0]  fmt;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  funct3;
    logic [31:0] mem_wdata;
    logic [15:0] count;

    int n_vec = 0, n_bad = 0;
    logic [63:0] m_addr;
    int          m_cnt;

    always #5 clk = ~clk;

    instr_encoder #(.ADDR_W(64), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_ready(in_ready), .fmt(fmt), .rd(rd), .rs1(rs1),
        .rs2(rs2), .funct3(funct3), .imm(imm), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .err(err), .count(count),
        .busy(busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference encoder: field placement with shifts/masks on plain integers
    function automatic longint unsigned ref_word(input int f, input longint unsigned i,
                                                 input int d, input int s1, input int s2,
                                                 input int f3);
        longint unsigned r = (longint'(s1) << 15) | (longint'(f3) << 12);
        case (f)
            0: r |= ((i & 'hFFF) << 20) | (longint'(d) << 7) | 'h13;
            1: r |= ((i & 'hFFF) << 20) | (longint'(d) << 7) | 'h03;
            2: r |= (((i >> 5) & 'h7F) << 25) | (longint'(s2) << 20) | ((i & 'h1F) << 7) | 'h23;
            default: r |= (((i >> 12) & 1) << 31) | (((i >> 5) & 'h3F) << 25)
                        | (longint'(s2) << 20) | (((i >> 1) & 'hF) << 8)
                        | (((i >> 11) & 1) << 7) | 'h63;
        endcase
        return r;
    endfunction

    function automatic bit ref_legal(input int f, input longint i);
        if (f == 3) return (i >= -4096) && (i <= 4094) && ((i & 1) == 0);
        return (i >= -2048) && (i <= 2047);
    endfunction

    task automatic do_start(input logic [63:0] base);
        @(negedge clk);
        start = 1; base_addr = base; in_valid = 1;   // start must win over in_valid
        @(posedge clk);
        @(negedge clk);
        start = 0; in_valid = 0;
        m_addr = base; m_cnt = 0;
        chk("start_addr", mem_addr, m_addr);
        chk("start_cnt", count, 0);
        chk("start_idle", busy, 0);
    endtask

    // One request; hold = cycles mem_ready stays low in WRITE; rst_mid = reset during WRITE
    task automatic do_req(input int f, input int d, input int s1, input int s2, input int f3,
                          input longint i, input int hold, input bit rst_mid);
        longint unsigned w;
        bit lg;
        w  = ref_word(f, i, d, s1, s2, f3) & 64'hFFFF_FFFF;
        lg = ref_legal(f, i);
        @(negedge clk);
        chk("ready_idle", in_ready, 1);
        in_valid = 1; fmt = 2'(f); rd = 5'(d); rs1 = 5'(s1); rs2 = 5'(s2);
        funct3 = 3'(f3); imm = i;
        @(posedge clk);                      // cycle N: accepted
        @(negedge clk);
        in_valid = 0;                        // scramble inputs: capture must hold
        fmt = 2'($urandom); rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
        funct3 = 3'($urandom); imm = {$urandom, $urandom};
        start = 1; base_addr = {$urandom, $urandom};   // ignored outside IDLE
        chk("enc_we", mem_we, 0);
        chk("enc_busy", busy, 1);
        @(posedge clk);
        @(negedge clk);                      // cycle N+2
        start = 0;
        if (!lg) begin
            chk("err_pulse", err, 1);
            chk("err_we", mem_we, 0);
            @(negedge clk);
            chk("err_clear", err, 0);
            chk("err_addr", mem_addr, m_addr);
            chk("err_cnt", count, 64'(m_cnt));
            return;
        end
        chk("wr_we", mem_we, 1);
        chk("wr_addr", mem_addr, m_addr);
        chk("wr_data", mem_wdata, w);
        chk("wr_err", err, 0);
        if (rst_mid) begin
            reset = 1;
            @(negedge clk);
            chk("rst_we", mem_we, 0);
            chk("rst_addr", mem_addr, 0);
            chk("rst_cnt", count, 0);
            reset = 0; #1;
            chk("rst_ready", in_ready, 1);
            m_addr = 0; m_cnt = 0;
            return;
        end
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("hold_we", mem_we, 1);
            chk("hold_addr", mem_addr, m_addr);
            chk("hold_data", mem_wdata, w);
            chk("hold_rdy", in_ready, 0);
        end
        mem_ready = 1;
        @(negedge clk);
        mem_ready = 0;
        m_addr += 4;
        if (m_cnt < 65535) m_cnt++;
        chk("done_we", mem_we, 0);
        chk("done_addr", mem_addr, m_addr);
        chk("done_cnt", count, 64'(m_cnt));
        chk("done_rdy", in_ready, 1);
        chk("done_data", mem_wdata, w);
    endtask

    function automatic longint pick_imm();
        longint edges[10] = '{-2049, -2048, 2047, 2048, -4097, -4096, 4094, 4095, 4096, 0};
        case ($urandom_range(0, 3))
            0: return longint'($urandom_range(0, 8400)) - 4200;
            1: return edges[$urandom_range(0, 9)];
            2: return longint'({$urandom, $urandom});
            default: return 2 * (longint'($urandom_range(0, 4095)) - 2048);
        endcase
    endfunction

    initial begin
        reset = 1; start = 0; in_valid = 0; mem_ready = 0; base_addr = 0;
        fmt = 0; rd = 0; rs1 = 0; rs2 = 0; funct3 = 0; imm = 0;
        m_addr = 0; m_cnt = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_we0", mem_we, 0);
        chk("rst_addr0", mem_addr, 0);
        chk("rst_data0", mem_wdata, 0);
        chk("rst_cnt0", count, 0);
        chk("rst_err0", err, 0);
        chk("rst_busy0", busy, 0);
        chk("rst_rdy_hi", in_ready, 0);
        reset = 0; #1;
        chk("rst_rdy_lo", in_ready, 1);

        // directed examples
        do_start(64'h1000);
        do_req(0, 5, 6, 0, 0, -1, 0, 0);
        chk("ex1_word", ref_word(0, -1, 5, 6, 0, 0), 64'hFFF30293);
        do_req(2, 0, 2, 5, 3, 8, 0, 0);
        chk("ex2_word", ref_word(2, 8, 0, 2, 5, 3), 64'h00513423);
        do_req(3, 0, 1, 2, 0, -4, 0, 0);
        chk("ex3_word", ref_word(3, -4, 0, 1, 2, 0) & 64'hFFFF_FFFF, 64'hFE208EE3);
        do_req(0, 1, 1, 0, 0, 2048, 0, 0);
        do_req(3, 0, 1, 2, 0, 3, 0, 0);
        do_req(1, 7, 8, 0, 2, 100, 3, 0);
        do_req(0, 3, 4, 0, 0, 5, 1, 1);      // reset mid-WRITE

        // randomized
        do_start({$urandom, $urandom} & ~64'h3);
        for (int t = 0; t < 60; t++) begin
            if ($urandom_range(0, 15) == 0)
                do_start({$urandom, $urandom});
            do_req($urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                   $urandom_range(0, 31), $urandom_range(0, 7), pick_imm(),
                   $urandom_range(0, 3), $urandom_range(0, 20) == 0);
        end
        do_start(64'hFFFF_FFFF_FFFF_FFFC);   // pointer wraps modulo 2^64
        do_req(0, 1, 2, 0, 0, 7, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
